pcfile_read_arb: RTL and testbench
==================================

PCFILE_READ_ARB -- requirements
Module: pcfile_read_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of PC-file read requesters.
REQ-002 SHALL have parameter NUM_PORTS, default 2: number of PC-file read ports shared.
REQ-003 SHALL have parameter ADDR_W, default 6: FetchID width.
REQ-004 SHALL have parameter DATA_W, default 32: PC-file entry width.
REQ-005 SHALL have parameter AGE_MAX, default 7: starvation threshold in cycles.
REQ-006 SHALL have port clk, input, 1: sole clock; all state on posedge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port IN_flush, input, 1: kill all grants this cycle and all in-flight responses.
REQ-009 SHALL have port IN_reqValid, input, NUM_REQ: per-requester read request.
REQ-010 SHALL have port IN_reqPrio, input, NUM_REQ: per-requester priority hint.
REQ-011 SHALL have port IN_reqAddr, input, NUM_REQ x ADDR_W: per-requester FetchID.
REQ-012 SHALL have port OUT_reqGrant, output, NUM_REQ: combinational same-cycle grant.
REQ-013 SHALL have port OUT_rdValid, output, NUM_PORTS: PC-file read enable per port.
REQ-014 SHALL have port OUT_rdAddr, output, NUM_PORTS x ADDR_W: PC-file read address per port.
REQ-015 SHALL have port IN_rdData, input, NUM_PORTS x DATA_W: PC-file read data, valid one cycle after OUT_rdValid.
REQ-016 SHALL have port OUT_respValid, output, NUM_REQ: response strobe per requester.
REQ-017 SHALL have port OUT_respData, output, NUM_REQ x DATA_W: response data per requester.

Function
REQ-018 SHALL treat requester i as urgent when IN_reqValid[i] and (IN_reqPrio[i] or age[i]==AGE_MAX).
REQ-019 SHALL grant up to NUM_PORTS requesters per cycle: urgent requesters first, then non-urgent; each class ordered round-robin starting at pointer rrPtr, wrapping from NUM_REQ-1 to 0.
REQ-020 SHALL assign granted requesters to ports in grant order (first grant -> port 0); unused ports drive OUT_rdValid=0, OUT_rdAddr=0.
REQ-021 SHALL assert OUT_reqGrant only for valid requesters; a requester whose valid is low SHALL never be granted.
REQ-022 SHALL, on IN_flush=1, drive OUT_reqGrant=0 and OUT_rdValid=0 that cycle and leave rrPtr and ages unchanged.
REQ-023 SHALL update rrPtr to (index of last granted requester + 1) mod NUM_REQ when at least one grant issues; otherwise hold.
REQ-024 SHALL keep a per-requester age counter (width clog2(AGE_MAX+1)): cleared on grant or when valid low; incremented, saturating at AGE_MAX, when valid and not granted.
REQ-025 SHALL register per port {valid, requester index} at grant; next cycle assert OUT_respValid[index]=1 with OUT_respData[index]=IN_rdData[port]; latency exactly 1 cycle grant-to-response.
REQ-026 SHALL suppress responses registered in the cycle before IN_flush=1 (the response due in the flush cycle is dropped).
REQ-027 SHALL drive OUT_respData[i]=0 when OUT_respValid[i]=0.
REQ-028 SHALL allow a requester to be regranted every cycle (back-to-back, full throughput per port).
REQ-029 SHALL, when more than NUM_PORTS requesters are urgent, grant urgent ones in round-robin order and defer the rest.

Reset
REQ-030 SHALL on rst=1 asynchronously set rrPtr=0, all ages=0, all response pipeline valids=0.
REQ-031 SHALL during reset drive OUT_reqGrant=0, OUT_rdValid=0, OUT_respValid=0, OUT_respData=0; no grants issue while rst=1.
REQ-032 SHALL drop any in-flight response when reset asserts mid-operation; first grant possible in first cycle with rst=0.

Verification
REQ-033 SHALL pass: after reset, req valid=4'b1111, prio=0 -> grants 0,1 (ports 0,1), next cycle 2,3, next 0,1; responses one cycle after each grant with port data.
REQ-034 SHALL pass: valid=4'b1111, prio=4'b1000, rrPtr=0 -> grants requesters 3 (port 0) and 0 (port 1).
REQ-035 SHALL pass: requester 3 valid with prio=0 while requesters 0,1 hold prio=1 continuously -> requester 3 granted in the cycle its age reaches 7 (8th cycle of waiting).
REQ-036 SHALL pass: grant to requester 2 in cycle N, IN_flush=1 in cycle N+1 -> OUT_respValid[2]=0 in N+1, no grants in N+1, rrPtr unchanged.
REQ-037 SHALL pass: rst asserted one cycle after grant to requester 1 -> OUT_respValid=0 immediately; after release, rrPtr=0 and valid=4'b0010 -> requester 1 granted on port 0.

Source files
------------

// File: rtl/pcfile_read_arb.sv
// Multi-port PC-file read arbiter: urgent-first round-robin grant of NUM_REQ requesters onto
// NUM_PORTS read ports, with starvation ageing and a one-cycle response return path.
module pcfile_read_arb #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int AGE_MAX   = 7
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                IN_flush,
    input  logic [NUM_REQ-1:0]                  IN_reqValid,
    input  logic [NUM_REQ-1:0]                  IN_reqPrio,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]      IN_reqAddr,
    output logic [NUM_REQ-1:0]                  OUT_reqGrant,
    output logic [NUM_PORTS-1:0]                OUT_rdValid,
    output logic [NUM_PORTS-1:0][ADDR_W-1:0]    OUT_rdAddr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]    IN_rdData,
    output logic [NUM_REQ-1:0]                  OUT_respValid,
    output logic [NUM_REQ-1:0][DATA_W-1:0]      OUT_respData
);

    localparam int AGE_W  = $clog2(AGE_MAX + 1);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned NREQ  = NUM_REQ;
    localparam int unsigned NPORT = NUM_PORTS;

    logic [IDX_W-1:0]                   rr_ptr;
    logic [IDX_W-1:0]                   rr_next;
    logic [NUM_REQ-1:0][AGE_W-1:0]      age;
    logic [NUM_REQ-1:0]                 urgent;
    logic [NUM_PORTS-1:0]               port_valid;
    logic [NUM_PORTS-1:0][IDX_W-1:0]    port_idx;
    logic [NUM_PORTS-1:0]               resp_pend;
    logic [NUM_PORTS-1:0][IDX_W-1:0]    resp_idx;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            urgent[i] = IN_reqValid[i] & (IN_reqPrio[i] | (age[i] == AGE_W'(AGE_MAX)));
        end
    end

    // Two sweeps from rr_ptr (urgent, then the rest); ports fill in grant order.
    always_comb begin
        int unsigned n_grant;
        int unsigned idx;
        OUT_reqGrant = '0;
        port_valid   = '0;
        port_idx     = '0;
        OUT_rdAddr   = '0;
        rr_next      = rr_ptr;
        n_grant      = 0;
        idx          = 0;
        if (!rst && !IN_flush) begin
            for (int unsigned pass = 0; pass < 2; pass++) begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    idx = (32'(rr_ptr) + k) % NREQ;
                    if (IN_reqValid[IDX_W'(idx)] && (urgent[IDX_W'(idx)] == (pass == 0))
                        && (n_grant < NPORT)) begin
                        OUT_reqGrant[IDX_W'(idx)]   = 1'b1;
                        port_valid[PORT_W'(n_grant)] = 1'b1;
                        port_idx[PORT_W'(n_grant)]   = IDX_W'(idx);
                        OUT_rdAddr[PORT_W'(n_grant)] = IN_reqAddr[IDX_W'(idx)];
                        rr_next                      = IDX_W'((idx + 1) % NREQ);
                        n_grant                      = n_grant + 1;
                    end
                end
            end
        end
    end

    assign OUT_rdValid = port_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            age       <= '0;
            resp_pend <= '0;
            resp_idx  <= '0;
        end else begin
            resp_pend <= port_valid;
            resp_idx  <= port_idx;
            if (!IN_flush) begin
                if (|port_valid) begin
                    rr_ptr <= rr_next;
                end
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (OUT_reqGrant[i] || !IN_reqValid[i]) begin
                        age[i] <= '0;
                    end else if (age[i] != AGE_W'(AGE_MAX)) begin
                        age[i] <= age[i] + AGE_W'(1);
                    end
                end
            end
        end
    end

    // Flush kills the response due this cycle, even though it was registered before.
    always_comb begin
        OUT_respValid = '0;
        OUT_respData  = '0;
        if (!rst && !IN_flush) begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                if (resp_pend[p]) begin
                    OUT_respValid[resp_idx[p]] = 1'b1;
                    OUT_respData[resp_idx[p]]  = IN_rdData[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_pcfile_read_arb.sv
// Self-checking bench for pcfile_read_arb: directed scenarios plus randomized traffic
// checked against a priority-key sorting model of the arbiter.
module tb_pcfile_read_arb;

    localparam int N  = 4;
    localparam int P  = 2;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int AM = 7;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [N-1:0]            valid;
    logic [N-1:0]            prio;
    logic [N-1:0][AW-1:0]    addr;
    logic [N-1:0]            grant;
    logic [P-1:0]            rd_valid;
    logic [P-1:0][AW-1:0]    rd_addr;
    logic [P-1:0][DW-1:0]    rd_data;
    logic [N-1:0]            resp_valid;
    logic [N-1:0][DW-1:0]    resp_data;

    int checks = 0;
    int errors = 0;

    pcfile_read_arb #(
        .NUM_REQ  (N),
        .NUM_PORTS(P),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .AGE_MAX  (AM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_flush     (flush),
        .IN_reqValid  (valid),
        .IN_reqPrio   (prio),
        .IN_reqAddr   (addr),
        .OUT_reqGrant (grant),
        .OUT_rdValid  (rd_valid),
        .OUT_rdAddr   (rd_addr),
        .IN_rdData    (rd_data),
        .OUT_respValid(resp_valid),
        .OUT_respData (resp_data)
    );

    always #5 clk = ~clk;

    // Reference model state: pointer, ages and responses owed next cycle.
    int m_rr;
    int m_age[N];
    bit m_pv[P];
    int m_pi[P];
    int g_list[$];
    logic [N-1:0]          e_grant;
    logic [P-1:0]          e_rdv;
    logic [P-1:0][AW-1:0]  e_rda;
    logic [N-1:0]          e_rspv;
    logic [N-1:0][DW-1:0]  e_rspd;

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        for (int p = 0; p < P; p++) begin
            m_pv[p] = 1'b0;
            m_pi[p] = 0;
        end
    endtask

    // Each valid requester gets key class*N + round-robin distance; lowest P keys win.
    task automatic model_eval();
        int keys[$];
        int cls;
        g_list.delete();
        e_grant = '0;
        e_rdv   = '0;
        e_rda   = '0;
        e_rspv  = '0;
        e_rspd  = '0;
        if (!rst && !flush) begin
            for (int i = 0; i < N; i++) begin
                if (valid[i]) begin
                    cls = (prio[i] || m_age[i] == AM) ? 0 : 1;
                    keys.push_back(cls * N + (i - m_rr + N) % N);
                end
            end
            keys.sort();
            for (int k = 0; k < keys.size() && k < P; k++)
                g_list.push_back((m_rr + keys[k] % N) % N);
            for (int p = 0; p < g_list.size(); p++) begin
                e_grant[g_list[p]] = 1'b1;
                e_rdv[p]           = 1'b1;
                e_rda[p]           = addr[g_list[p]];
            end
            for (int p = 0; p < P; p++) begin
                if (m_pv[p]) begin
                    e_rspv[m_pi[p]] = 1'b1;
                    e_rspd[m_pi[p]] = rd_data[p];
                end
            end
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < P; p++) begin
                m_pv[p] = (p < g_list.size());
                m_pi[p] = (p < g_list.size()) ? g_list[p] : 0;
            end
            if (!flush) begin
                for (int i = 0; i < N; i++) begin
                    if (e_grant[i] || !valid[i]) m_age[i] = 0;
                    else if (m_age[i] < AM) m_age[i] = m_age[i] + 1;
                end
                if (g_list.size() > 0) m_rr = (g_list[g_list.size()-1] + 1) % N;
            end
        end
    endtask

    task automatic new_data();
        for (int i = 0; i < N; i++) addr[i] = AW'($urandom);
        for (int p = 0; p < P; p++) rd_data[p] = $urandom;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
        new_data();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        valid = '0;
        prio  = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        new_data();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        valid = '1;
        prio  = '1;
        new_data();
        @(negedge clk);
        #1;
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
        checks++; if (rd_valid !== '0) begin errors++; $display("FAIL reset_rdvalid got=%b exp=0", rd_valid); end
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_respvalid got=%b exp=0", resp_valid); end
        checks++; if (resp_data !== '0) begin errors++; $display("FAIL reset_respdata got=%h exp=0", resp_data); end
        do_reset();
    endtask

    task automatic test_round_robin();
        do_reset();
        valid = 4'b1111;
        prio  = 4'b0000;
        #1;
        checks++; if (grant !== 4'b0011) begin errors++; $display("FAIL rr_c1_grant got=%b exp=0011", grant); end
        checks++; if (rd_valid !== 2'b11) begin errors++; $display("FAIL rr_c1_rdvalid got=%b exp=11", rd_valid); end
        checks++; if (rd_addr !== {addr[1], addr[0]}) begin errors++; $display("FAIL rr_c1_rdaddr got=%h exp=%h", rd_addr, {addr[1], addr[0]}); end
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL rr_c1_resp got=%b exp=0", resp_valid); end
        tick();
        #1;
        checks++; if (grant !== 4'b1100) begin errors++; $display("FAIL rr_c2_grant got=%b exp=1100", grant); end
        checks++; if (rd_addr !== {addr[3], addr[2]}) begin errors++; $display("FAIL rr_c2_rdaddr got=%h exp=%h", rd_addr, {addr[3], addr[2]}); end
        checks++; if (resp_valid !== 4'b0011) begin errors++; $display("FAIL rr_c2_resp got=%b exp=0011", resp_valid); end
        checks++; if (resp_data !== {32'h0, 32'h0, rd_data[1], rd_data[0]}) begin errors++; $display("FAIL rr_c2_data got=%h", resp_data); end
        tick();
        #1;
        checks++; if (grant !== 4'b0011) begin errors++; $display("FAIL rr_c3_grant got=%b exp=0011", grant); end
        checks++; if (resp_valid !== 4'b1100) begin errors++; $display("FAIL rr_c3_resp got=%b exp=1100", resp_valid); end
        checks++; if (resp_data !== {rd_data[1], rd_data[0], 32'h0, 32'h0}) begin errors++; $display("FAIL rr_c3_data got=%h", resp_data); end
        tick();
    endtask

    task automatic test_prio();
        do_reset();
        valid = 4'b1111;
        prio  = 4'b1000;
        #1;
        checks++; if (grant !== 4'b1001) begin errors++; $display("FAIL prio_grant got=%b exp=1001", grant); end
        checks++; if (rd_addr !== {addr[0], addr[3]}) begin errors++; $display("FAIL prio_rdaddr got=%h exp=%h", rd_addr, {addr[0], addr[3]}); end
        tick();
    endtask

    task automatic test_starvation();
        do_reset();
        valid = 4'b1011;
        prio  = 4'b0011;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (c < 8) begin
                checks++; if (grant !== 4'b0011) begin errors++; $display("FAIL starve_c%0d_grant got=%b exp=0011", c, grant); end
            end else begin
                checks++; if (grant !== 4'b1001) begin errors++; $display("FAIL starve_c8_grant got=%b exp=1001", grant); end
                checks++; if (rd_addr[0] !== addr[3]) begin errors++; $display("FAIL starve_c8_port0 got=%h exp=%h", rd_addr[0], addr[3]); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        valid = 4'b0100;
        prio  = 4'b0000;
        #1;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL flush_n_grant got=%b exp=0100", grant); end
        tick();
        flush = 1'b1;
        valid = 4'b1111;
        #1;
        checks++; if (grant !== '0) begin errors++; $display("FAIL flush_grant got=%b exp=0", grant); end
        checks++; if (rd_valid !== '0) begin errors++; $display("FAIL flush_rdvalid got=%b exp=0", rd_valid); end
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL flush_resp got=%b exp=0", resp_valid); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (grant !== 4'b1001) begin errors++; $display("FAIL flush_after_grant got=%b exp=1001", grant); end
        checks++; if (rd_addr[0] !== addr[3]) begin errors++; $display("FAIL flush_after_port0 got=%h exp=%h", rd_addr[0], addr[3]); end
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL flush_after_resp got=%b exp=0", resp_valid); end
        tick();
    endtask

    task automatic test_reset_midop();
        do_reset();
        valid = 4'b0010;
        prio  = 4'b0000;
        #1;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL midrst_grant got=%b exp=0010", grant); end
        tick();
        #1;
        checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL midrst_resp_before got=%b exp=0010", resp_valid); end
        rst = 1'b1;
        #1;
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL midrst_resp got=%b exp=0", resp_valid); end
        checks++; if (resp_data !== '0) begin errors++; $display("FAIL midrst_data got=%h exp=0", resp_data); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL midrst_after_grant got=%b exp=0010", grant); end
        checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL midrst_after_rdvalid got=%b exp=01", rd_valid); end
        checks++; if (rd_addr[0] !== addr[1]) begin errors++; $display("FAIL midrst_after_port0 got=%h exp=%h", rd_addr[0], addr[1]); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            valid = N'($urandom);
            prio  = N'($urandom & $urandom & $urandom);
            #1;
            model_eval();
            checks++; if (grant !== e_grant) begin errors++; $display("FAIL rand%0d_grant got=%b exp=%b", c, grant, e_grant); end
            checks++; if (rd_valid !== e_rdv) begin errors++; $display("FAIL rand%0d_rdvalid got=%b exp=%b", c, rd_valid, e_rdv); end
            checks++; if (rd_addr !== e_rda) begin errors++; $display("FAIL rand%0d_rdaddr got=%h exp=%h", c, rd_addr, e_rda); end
            checks++; if (resp_valid !== e_rspv) begin errors++; $display("FAIL rand%0d_resp got=%b exp=%b", c, resp_valid, e_rspv); end
            checks++; if (resp_data !== e_rspd) begin errors++; $display("FAIL rand%0d_data got=%h exp=%h", c, resp_data, e_rspd); end
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        valid = '0;
        prio  = '0;
        addr  = '0;
        rd_data = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_prio();
        test_starvation();
        test_flush();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
